// File: rtl/peripheral_spram_arbiter_tl.sv
// peripheral_spram_arbiter_tl: two-requester round-robin arbiter in front of a single-port RAM
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mN_req_i          request from requester N (0/1), held until granted
//   mN_we_i           1 = write, 0 = read
//   mN_be_i           16-bit lane enables (BEW = XLEN/16 lanes)
//   mN_addr_i         word address
//   mN_data_i         write data
//   mN_gnt_o          request accepted this cycle (combinational)
//   mN_rvalid_o       one-cycle read-data-valid pulse for requester N
//   mN_rdata_o        read data, held between reads
//   mem_req_o         RAM access strobe
//   mem_we_o          RAM write enable
//   mem_be_o          RAM lane enables
//   mem_addr_o        RAM address
//   mem_data_o        RAM write data
//   mem_data_i        RAM read data, valid the cycle after a read strobe
module peripheral_spram_arbiter_tl #(
    parameter int  PLEN = 64,
    parameter int  XLEN = 64,
    localparam int BEW  = XLEN / 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [BEW-1:0]  m0_be_i,
    input  logic [PLEN-1:0] m0_addr_i,
    input  logic [XLEN-1:0] m0_data_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic [XLEN-1:0] m0_rdata_o,
    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [BEW-1:0]  m1_be_i,
    input  logic [PLEN-1:0] m1_addr_i,
    input  logic [XLEN-1:0] m1_data_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [XLEN-1:0] m1_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [BEW-1:0]  mem_be_o,
    output logic [PLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_data_o,
    input  logic [XLEN-1:0] mem_data_i
);
    typedef enum logic {IDLE, RD_WAIT} state_t;
    state_t state, state_nxt;
    logic   prio;
    logic   owner;
    logic   rd_gnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE && rd_gnt) state_nxt = RD_WAIT;
    end
    // Grants are gated by rst so nothing leaks to the RAM while reset is held.
    always_comb begin
        m0_gnt_o   = !rst && state == IDLE && m0_req_i && (!m1_req_i || !prio);
        m1_gnt_o   = !rst && state == IDLE && m1_req_i && (!m0_req_i || prio);
        rd_gnt     = (m0_gnt_o && !m0_we_i) || (m1_gnt_o && !m1_we_i);
        mem_req_o  = m0_gnt_o || m1_gnt_o;
        mem_we_o   = m0_gnt_o ? m0_we_i   : m1_gnt_o ? m1_we_i   : 1'b0;
        mem_be_o   = m0_gnt_o ? m0_be_i   : m1_gnt_o ? m1_be_i   : '0;
        mem_addr_o = m0_gnt_o ? m0_addr_i : m1_gnt_o ? m1_addr_i : '0;
        mem_data_o = m0_gnt_o ? m0_data_i : m1_gnt_o ? m1_data_i : '0;
    end
    // prio points at whoever lost (or was absent) on the last grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio  <= 1'b0;
            owner <= 1'b0;
        end else begin
            if (mem_req_o) prio  <= m0_gnt_o;
            if (rd_gnt)    owner <= m1_gnt_o;
        end
    end
    // RAM data is captured at the end of RD_WAIT and returned only to the owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rvalid_o <= 1'b0;
            m1_rvalid_o <= 1'b0;
            m0_rdata_o  <= '0;
            m1_rdata_o  <= '0;
        end else begin
            m0_rvalid_o <= state == RD_WAIT && !owner;
            m1_rvalid_o <= state == RD_WAIT && owner;
            if (state == RD_WAIT && !owner) m0_rdata_o <= mem_data_i;
            if (state == RD_WAIT && owner)  m1_rdata_o <= mem_data_i;
        end
    end
endmodule
